shift_serializer: RTL

SHIFT_SERIALIZER -- requirements
Module: shift_serializer

---
 rtl/shifter_pkg.sv | 14 +
 rtl/shift_fifo.sv | 51 +++++
 rtl/shift_serializer.sv | 130 +++++++++++++
 3 files changed

// File: rtl/shifter_pkg.sv
// Shared FSM state encoding and shift-order constants for the serializer.
// Latency: none; types and constants only.
// Backpressure: none.
package shifter_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam bit ORDER_MSB_FIRST = 1'b0;
  localparam bit ORDER_LSB_FIRST = 1'b1;

endpackage

// File: rtl/shift_fifo.sv
// Word FIFO ahead of the shift register; head is always visible on head_dat.
// Latency: a pushed word is at the head one edge later when the FIFO was empty.
// Backpressure: full is taken from the pointers; a pop never frees a slot in the same cycle.
module shift_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_dat,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wptr_q;
  logic [AW:0]      rptr_q;
  logic [AW:0]      level_q;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + ONE;
      if (pop)  rptr_q <= rptr_q + ONE;
      if (push && !pop)      level_q <= level_q + ONE;
      else if (pop && !push) level_q <= level_q - ONE;
    end
  end

  // Storage needs no reset: validity is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= push_dat;
  end

  assign head_dat = mem_q[rptr_q[AW-1:0]];
  assign empty    = (wptr_q == rptr_q);
  assign full     = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level    = level_q;

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial shifter fed by a small word FIFO, DIV clocks per bit.
// Latency: word written at edge N drives its first bit after edge N+1.
// Backpressure: in_ready drops while the FIFO holds DEPTH words; held words are never lost.
module shift_serializer
  import shifter_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 4,
  parameter bit LSB_FIRST    = ORDER_MSB_FIRST,
  parameter bit DIFFERENTIAL = 1'b0,
  parameter int DIV          = 1,
  parameter bit IDLE_LEVEL   = 1'b0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out,
  output logic                     negout,
  output logic                     busy,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int BW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] BIT_ONE  = BW'(1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [WIDTH-1:0] shreg_d;
  logic [BW-1:0]    bit_q;
  logic [DW-1:0]    div_q;
  logic             out_q;

  logic [WIDTH-1:0] head_dat;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             bit_done;
  logic             word_done;

  // Bit that goes on the line first for a freshly loaded word.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST == ORDER_LSB_FIRST) ? w[0] : w[WIDTH-1];
  endfunction

  shift_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .push_dat (in_data),
    .pop      (pop),
    .head_dat (head_dat),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .level    (level)
  );

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign bit_done  = (div_q == DIV_LAST);
  assign word_done = (state_q == ST_SHIFT) && bit_done && (bit_q == BIT_LAST);
  assign pop       = !fifo_empty && ((state_q == ST_IDLE) || word_done);

  // Rotate so the next bit to send always sits in the first-bit position.
  always_comb begin
    shreg_d = shreg_q;
    if (LSB_FIRST == ORDER_LSB_FIRST) shreg_d = {shreg_q[0], shreg_q[WIDTH-1:1]};
    else                              shreg_d = {shreg_q[WIDTH-2:0], shreg_q[WIDTH-1]};
  end

  // IDLE/SHIFT sequencer with divider and bit counters; reloads with no gap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      shreg_q <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      out_q   <= IDLE_LEVEL;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pop) begin
            state_q <= ST_SHIFT;
            shreg_q <= head_dat;
            out_q   <= first_bit(head_dat);
            bit_q   <= '0;
            div_q   <= '0;
          end
        end
        ST_SHIFT: begin
          if (!bit_done) begin
            div_q <= div_q + DIV_ONE;
          end else begin
            div_q <= '0;
            if (bit_q != BIT_LAST) begin
              bit_q   <= bit_q + BIT_ONE;
              shreg_q <= shreg_d;
              out_q   <= first_bit(shreg_d);
            end else if (pop) begin
              bit_q   <= '0;
              shreg_q <= head_dat;
              out_q   <= first_bit(head_dat);
            end else begin
              bit_q   <= '0;
              state_q <= ST_IDLE;
              out_q   <= IDLE_LEVEL;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign out    = out_q;
  assign negout = DIFFERENTIAL ? ~out_q : 1'b0;
  assign busy   = (state_q == ST_SHIFT);
  assign empty  = fifo_empty && (state_q == ST_IDLE);

endmodule
